y_deser: RTL

Downstream capture stage for the 4-to-1 data-selector (`test6`) output `Y`.
- Samples `Y` on a qualifying strobe while the upstream sequencer sweeps select lines A/B and data inputs D.
- Assembles WIDTH consecutive samples MSB-first into a parallel word.
- Presents the word on a valid/ready handshake, so selector behaviour can be checked as whole words instead of by eye on a waveform.
- Flags samples lost while a finished word is waiting.

---
 rtl/y_deser_defs.sv | 12 +
 rtl/shift_reg_w.sv | 23 ++
 rtl/y_deser.sv | 128 ++++++++++++
 3 files changed

// File: rtl/y_deser_defs.sv
// Shared definitions for the y_deser capture stage: FSM encodings and default word width.
package y_deser_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/shift_reg_w.sv
// WIDTH-bit left shift register: serial input enters at the LSB, synchronous clear wins over shift.
module shift_reg_w #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q_q <= '0;
    else if (clr_i) q_q <= '0;
    else if (en_i)  q_q <= {q_q[WIDTH-2:0], d_i};
  end

  assign q_o = q_q;

endmodule

// File: rtl/y_deser.sv
// Serial-to-parallel capture of selector output Y with valid/ready word handoff and sticky overrun.
// Optional even-parity output is compiled in with `define Y_DESER_PARITY_EN.
module y_deser
  import y_deser_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             y_in,
  input  logic             y_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             overrun
`ifdef Y_DESER_PARITY_EN
  ,
  output logic             parity_out
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             wvalid_q, wvalid_d;
  logic             ovr_q, ovr_d;
  logic             sh_clr, sh_en;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_next;
  logic             sh_msb_unused;

  shift_reg_w #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (sh_clr),
    .en_i  (sh_en),
    .d_i   (y_in),
    .q_o   (sh_q)
  );

  // The completed word is the value the register would hold after the last shift,
  // so the MSB still held by the register is never needed.
  assign sh_next       = {sh_q[WIDTH-2:0], y_in};
  assign sh_msb_unused = sh_q[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      word_q   <= '0;
      wvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      wvalid_q <= wvalid_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    wvalid_d = wvalid_q;
    ovr_d    = ovr_q;
    sh_clr   = 1'b0;
    sh_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sh_clr  = 1'b1;
          ovr_d   = 1'b0;
        end
      end
      SHIFT: begin
        // Restart beats a same-cycle sample; that sample is silently lost.
        if (start) begin
          cnt_d  = '0;
          sh_clr = 1'b1;
        end else if (y_valid) begin
          sh_en = 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            word_d   = sh_next;
            wvalid_d = 1'b1;
            cnt_d    = '0;
            state_d  = HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (y_valid) ovr_d = 1'b1;
        if (word_ready) begin
          wvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign word_out   = word_q;
  assign word_valid = wvalid_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = ovr_q;

`ifdef Y_DESER_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                              par_q <= 1'b0;
    else if (state_q == SHIFT && !start && y_valid &&
             cnt_q == CW'(WIDTH - 1))                        par_q <= ^sh_next;
  end

  assign parity_out = par_q;
`endif

endmodule
